sram_latency_mem: RTL and testbench



---
 rtl/sram_latency_mem_if.sv | 33 +++
 rtl/sram_latency_mem.sv | 152 +++++++++++++++
 tb/tb_sram_latency_mem.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sram_latency_mem_if.sv
// Request/response bundle between the SRAM controller (master) and sram_latency_mem (slave).
// The parity pins exist only when SRAM_PARITY_EN is defined.
interface sram_latency_mem_if;
  logic [31:0] sram_addr;
  logic [31:0] sram_data_in;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] sram_data_out;
  logic        sram_write_done;
  logic        sram_read_done;
`ifdef SRAM_PARITY_EN
  logic        sram_par_inject;
  logic        sram_parity_err;

  modport master (
    output sram_addr, sram_data_in, wr_en, rd_en, sram_par_inject,
    input  sram_data_out, sram_write_done, sram_read_done, sram_parity_err
  );
  modport slave (
    input  sram_addr, sram_data_in, wr_en, rd_en, sram_par_inject,
    output sram_data_out, sram_write_done, sram_read_done, sram_parity_err
  );
`else
  modport master (
    output sram_addr, sram_data_in, wr_en, rd_en,
    input  sram_data_out, sram_write_done, sram_read_done
  );
  modport slave (
    input  sram_addr, sram_data_in, wr_en, rd_en,
    output sram_data_out, sram_write_done, sram_read_done
  );
`endif
endinterface

// File: rtl/sram_latency_mem.sv
// Single-port 32-bit SRAM with programmable write/read latency and one-cycle done pulses.
// Optional even-parity storage and checking is enabled with SRAM_PARITY_EN.
module sram_latency_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int WR_LATENCY = 2,
  parameter int RD_LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  sram_latency_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef SRAM_PARITY_EN
  localparam int MEM_W = 33;
`else
  localparam int MEM_W = 32;
`endif
  localparam logic [3:0] WR_CNT = 4'(WR_LATENCY - 1);
  localparam logic [3:0] RD_CNT = 4'(RD_LATENCY - 1);

  logic [MEM_W-1:0] mem [DEPTH] = '{default: '0};

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [MEM_W-1:0]      wdata_q, wdata_d;
  logic [31:0]           data_out_q, data_out_d;
  logic                  wr_done_q, wr_done_d;
  logic                  rd_done_q, rd_done_d;
  logic                  mem_we;
  logic [MEM_W-1:0]      rd_word;
`ifdef SRAM_PARITY_EN
  logic                  perr_q, perr_d;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.sram_addr[31:ADDR_WIDTH+2], bus.sram_addr[1:0]};

  function automatic logic [MEM_W-1:0] pack_word(input logic [31:0] data, input logic inject);
`ifdef SRAM_PARITY_EN
    pack_word = {(^data) ^ inject, data};
`else
    pack_word = data;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_wr_d    = op_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    data_out_d = data_out_q;
    wr_done_d  = (state_q == DONE) && op_wr_q;
    rd_done_d  = (state_q == DONE) && !op_wr_q;
    mem_we     = 1'b0;
    rd_word    = '0;
`ifdef SRAM_PARITY_EN
    perr_d     = perr_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          op_wr_d = 1'b1;
          idx_d   = bus.sram_addr[ADDR_WIDTH+1:2];
`ifdef SRAM_PARITY_EN
          wdata_d = pack_word(bus.sram_data_in, bus.sram_par_inject);
`else
          wdata_d = pack_word(bus.sram_data_in, 1'b0);
`endif
          cnt_d   = WR_CNT;
          state_d = (WR_CNT == 4'd0) ? DONE : BUSY;
        end else if (bus.rd_en) begin
          op_wr_d = 1'b0;
          idx_d   = bus.sram_addr[ADDR_WIDTH+1:2];
          cnt_d   = RD_CNT;
          state_d = (RD_CNT == 4'd0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The array is accessed on the edge that enters DONE; the done pulse follows one edge later.
    if (state_d == DONE && state_q != DONE) begin
      if (op_wr_d) begin
        mem_we = 1'b1;
      end else begin
        rd_word    = mem[idx_d];
        data_out_d = rd_word[31:0];
`ifdef SRAM_PARITY_EN
        perr_d     = (^rd_word[31:0]) ^ rd_word[32];
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      op_wr_q    <= 1'b0;
      data_out_q <= '0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
`ifdef SRAM_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_wr_q    <= op_wr_d;
      data_out_q <= data_out_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
`ifdef SRAM_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
  end

  // A reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[idx_d] <= wdata_d;
    end
  end

  assign bus.sram_data_out   = data_out_q;
  assign bus.sram_write_done = wr_done_q;
  assign bus.sram_read_done  = rd_done_q;
`ifdef SRAM_PARITY_EN
  assign bus.sram_parity_err = perr_q;
`endif
endmodule

// File: tb/tb_sram_latency_mem.sv
// Directed bench for sram_latency_mem: one default-latency instance and one with WR=4/RD=3.
// Parity vectors are included when SRAM_PARITY_EN is defined.
module tb_sram_latency_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   pulses;

  always #5 clk = ~clk;

  sram_latency_mem_if bus1 ();
  sram_latency_mem_if bus2 ();

  sram_latency_mem #(.ADDR_WIDTH(10), .WR_LATENCY(2), .RD_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst),  .bus(bus1)
  );
  sram_latency_mem #(.ADDR_WIDTH(10), .WR_LATENCY(4), .RD_LATENCY(3)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int sel, input logic rd);
    if (sel == 0) return rd ? bus1.sram_read_done : bus1.sram_write_done;
    return rd ? bus2.sram_read_done : bus2.sram_write_done;
  endfunction

  task automatic drive(input int sel, input logic we, input logic re,
                       input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    if (sel == 0) begin
      bus1.wr_en = we; bus1.rd_en = re; bus1.sram_addr = addr; bus1.sram_data_in = data;
    end else begin
      bus2.wr_en = we; bus2.rd_en = re; bus2.sram_addr = addr; bus2.sram_data_in = data;
    end
  endtask

  // exp_edges counts clock edges from now until the done pulse is visible.
  task automatic wait_done(input string tag, input int sel, input logic rd, input int exp_edges);
    int   n = 0;
    int   other = 0;
    logic got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done_of(sel, rd)) got = 1'b1;
      if (done_of(sel, !rd)) other++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(exp_edges));
    chk({tag, "_other"}, 32'(other), 32'd0);
    if (sel == 0) begin
      if (rd) bus1.rd_en = 1'b0; else bus1.wr_en = 1'b0;
    end else begin
      if (rd) bus2.rd_en = 1'b0; else bus2.wr_en = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(done_of(sel, rd)), 32'd0);
  endtask

  initial begin
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.sram_addr = '0; bus1.sram_data_in = '0;
    bus2.wr_en = 1'b0; bus2.rd_en = 1'b0; bus2.sram_addr = '0; bus2.sram_data_in = '0;
`ifdef SRAM_PARITY_EN
    bus1.sram_par_inject = 1'b0;
    bus2.sram_par_inject = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout",  bus1.sram_data_out, 32'h0);
    chk("rst_wdone", 32'(bus1.sram_write_done), 32'd0);
    chk("rst_rdone", 32'(bus1.sram_read_done), 32'd0);
    chk("rst_state", 32'(dut1.state_q), 32'd0);
    chk("rst_dout2", bus2.sram_data_out, 32'h0);
`ifdef SRAM_PARITY_EN
    chk("rst_perr",  32'(bus1.sram_parity_err), 32'd0);
`endif
    rst  = 1'b0;
    rst2 = 1'b0;

    // Write then read at default latency.
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    wait_done("wr10", 0, 1'b0, 3);
    drive(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
    wait_done("rd10", 0, 1'b1, 3);
    chk("rd10_data", bus1.sram_data_out, 32'hDEAD_BEEF);
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0BAD_F00D);
    wait_done("wr10b", 0, 1'b0, 3);
    chk("wr_hold_dout", bus1.sram_data_out, 32'hDEAD_BEEF);
    drive(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
    wait_done("rd10b", 0, 1'b1, 3);
    chk("rd10b_data", bus1.sram_data_out, 32'h0BAD_F00D);

    // Upper address bits alias onto the same word.
    drive(0, 1'b1, 1'b0, 32'h0000_1004, 32'h1234_5678);
    wait_done("wr_alias", 0, 1'b0, 3);
    drive(0, 1'b0, 1'b1, 32'h0000_0004, 32'h0);
    wait_done("rd_alias", 0, 1'b1, 3);
    chk("alias_data", bus1.sram_data_out, 32'h1234_5678);
    drive(0, 1'b0, 1'b1, 32'h0000_0300, 32'h0);
    wait_done("rd_blank", 0, 1'b1, 3);
    chk("blank_data", bus1.sram_data_out, 32'h0);

    // Simultaneous requests: write first, read captured on the following IDLE edge.
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
    wait_done("sim_wr", 0, 1'b0, 3);
    wait_done("sim_rd", 0, 1'b1, 2);
    chk("sim_data", bus1.sram_data_out, 32'hA5A5_A5A5);

`ifdef SRAM_PARITY_EN
    bus1.sram_par_inject = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0001);
    wait_done("par_wr1", 0, 1'b0, 3);
    bus1.sram_par_inject = 1'b0;
    drive(0, 1'b0, 1'b1, 32'h0000_0080, 32'h0);
    wait_done("par_rd1", 0, 1'b1, 3);
    chk("par_err1", 32'(bus1.sram_parity_err), 32'd1);
    chk("par_data1", bus1.sram_data_out, 32'h0000_0001);
    drive(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0001);
    wait_done("par_wr2", 0, 1'b0, 3);
    chk("par_hold", 32'(bus1.sram_parity_err), 32'd1);
    drive(0, 1'b0, 1'b1, 32'h0000_0080, 32'h0);
    wait_done("par_rd2", 0, 1'b1, 3);
    chk("par_err2", 32'(bus1.sram_parity_err), 32'd0);
`endif

    // Reset two edges after capture drops an in-flight write.
    drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'h1111_1111);
    wait_done("d2_wr", 1, 1'b0, 5);
    drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'hFFFF_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst2 = 1'b1;
    bus2.wr_en = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(posedge clk); #1;
      pulses += int'(bus2.sram_write_done) + int'(bus2.sram_read_done);
    end
    chk("d2_rst_pulses", 32'(pulses), 32'd0);
    chk("d2_rst_state", 32'(dut2.state_q), 32'd0);
    rst2 = 1'b0;
    drive(1, 1'b0, 1'b1, 32'h0000_0040, 32'h0);
    wait_done("d2_rd", 1, 1'b1, 4);
    chk("d2_rd_data", bus2.sram_data_out, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
